commit_ctrl: RTL and testbench

Sequences in-order retirement from the ROB head into the renamed register file, the store path and the fetch redirect. Each cycle it inspects the ROB head and, when the head is ready, drives the reg-file commit port, hands stores to the LSB (with ack handshake), or triggers a pipeline flush on branch mispredict. Sits between ROB, Reg, LSB and IFetch; it is the only source of rob_clear_up.

---
 rtl/commit_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_commit_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_ctrl.sv
// commit_ctrl -- in-order retirement sequencer at the ROB head.
//
// Each cycle it looks at the ROB head. When the head is valid and its result
// is ready, it does one of the following:
//   - REG / BRANCH: writes the register file through the commit port.
//   - STORE: hands the store to the LSB and waits for store_commit_ack.
//   - mispredicted BRANCH: pulses rob_clear_up and redirect.
//   - HALT: stops retirement.
// All outputs are registered.
//
// Optional feature: define COMMIT_CNT_EN to build the retired and mispredict
// counters. Without it, retired_cnt and mispred_cnt are tied to 0 and no
// counter registers exist.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   rdy_in                global ready; low freezes every register
//   head_*                ROB head view: valid, ready, type, rd, value,
//                         entry, mispredict, target
//   rob_pop               pulse: ROB advances its head
//   rob_commit_reg        pulse: reg-file write of commit_reg_id/data
//   commit_reg_id/data    register write payload
//   commit_rob_entry      ROB entry being retired
//   store_commit_valid    level request to the LSB, held until ack
//   store_commit_entry    ROB entry of the store
//   store_commit_ack      LSB accepted/performed the store
//   rob_clear_up          pulse: flush all speculative state
//   redirect_valid/pc     pulse: fetch redirect and its target
//   halt_out              sticky halt
//   retired_cnt           retirement count (COMMIT_CNT_EN)
//   mispred_cnt           mispredict count (COMMIT_CNT_EN)
//   fsm_state             current FSM state, for observation
//
// Handshake: store_commit_valid rises with store_commit_entry stable and stays
// high until a cycle in which store_commit_ack is sampled high. That cycle
// completes the transfer. The ack may arrive in the first cycle valid is high.
module commit_ctrl #(
  parameter int ROB_BIT    = 5,
  parameter int FLUSH_WAIT = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               head_valid,
  input  logic               head_ready,
  input  logic [1:0]         head_type,
  input  logic [4:0]         head_rd,
  input  logic [31:0]        head_value,
  input  logic [ROB_BIT-1:0] head_entry,
  input  logic               head_mispredict,
  input  logic [31:0]        head_target,
  output logic               rob_pop,
  output logic               rob_commit_reg,
  output logic [4:0]         commit_reg_id,
  output logic [31:0]        commit_reg_data,
  output logic [ROB_BIT-1:0] commit_rob_entry,
  output logic               store_commit_valid,
  output logic [ROB_BIT-1:0] store_commit_entry,
  input  logic               store_commit_ack,
  output logic               rob_clear_up,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic               halt_out,
  output logic [31:0]        retired_cnt,
  output logic [31:0]        mispred_cnt,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_WAIT_ST = 2'd1,
    S_FLUSH   = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam logic [1:0] T_REG    = 2'd0;
  localparam logic [1:0] T_STORE  = 2'd1;
  localparam logic [1:0] T_BRANCH = 2'd2;
  localparam logic [1:0] T_HALT   = 2'd3;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_WAIT);

  state_t             state, state_n;
  logic [3:0]         flush_cnt, flush_cnt_n;
  logic               rob_pop_n, rob_commit_reg_n, rob_clear_up_n, redirect_valid_n;
  logic [4:0]         commit_reg_id_n;
  logic [31:0]        commit_reg_data_n, redirect_pc_n;
  logic [ROB_BIT-1:0] commit_rob_entry_n, store_commit_entry_n;
  logic               store_commit_valid_n, halt_n;

  assign fsm_state = state;

  always_comb begin
    state_n              = state;
    flush_cnt_n          = flush_cnt;
    rob_pop_n            = 1'b0;
    rob_commit_reg_n     = 1'b0;
    rob_clear_up_n       = 1'b0;
    redirect_valid_n     = 1'b0;
    commit_reg_id_n      = commit_reg_id;
    commit_reg_data_n    = commit_reg_data;
    commit_rob_entry_n   = commit_rob_entry;
    store_commit_valid_n = store_commit_valid;
    store_commit_entry_n = store_commit_entry;
    redirect_pc_n        = redirect_pc;
    halt_n               = halt_out;

    case (state)
      S_RUN: begin
        // rob_pop high means the ROB is advancing this very cycle. The head
        // we see is the entry just retired, so skip it once.
        if (head_valid && head_ready && !rob_pop) begin
          case (head_type)
            T_REG, T_BRANCH: begin
              rob_pop_n          = 1'b1;
              rob_commit_reg_n   = (head_rd != 5'd0);
              commit_reg_id_n    = head_rd;
              commit_reg_data_n  = head_value;
              commit_rob_entry_n = head_entry;
              if (head_type == T_BRANCH && head_mispredict) begin
                rob_clear_up_n   = 1'b1;
                redirect_valid_n = 1'b1;
                redirect_pc_n    = head_target;
                flush_cnt_n      = FLUSH_INIT;
                state_n          = S_FLUSH;
              end
            end
            T_STORE: begin
              store_commit_valid_n = 1'b1;
              store_commit_entry_n = head_entry;
              state_n              = S_WAIT_ST;
            end
            T_HALT: begin
              rob_pop_n          = 1'b1;
              commit_rob_entry_n = head_entry;
              halt_n             = 1'b1;
              state_n            = S_HALT;
            end
            default: ;
          endcase
        end
      end
      S_WAIT_ST: begin
        if (store_commit_ack) begin
          store_commit_valid_n = 1'b0;
          rob_pop_n            = 1'b1;
          commit_rob_entry_n   = store_commit_entry;
          state_n              = S_RUN;
        end
      end
      S_FLUSH: begin
        // Leave on the edge where the count reaches zero.
        if (flush_cnt <= 4'd1) begin
          flush_cnt_n = 4'd0;
          state_n     = S_RUN;
        end else begin
          flush_cnt_n = flush_cnt - 4'd1;
        end
      end
      S_HALT: ;
      default: state_n = S_RUN;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state              <= S_RUN;
      flush_cnt          <= 4'd0;
      rob_pop            <= 1'b0;
      rob_commit_reg     <= 1'b0;
      rob_clear_up       <= 1'b0;
      redirect_valid     <= 1'b0;
      commit_reg_id      <= 5'd0;
      commit_reg_data    <= 32'd0;
      commit_rob_entry   <= '0;
      store_commit_valid <= 1'b0;
      store_commit_entry <= '0;
      redirect_pc        <= 32'd0;
      halt_out           <= 1'b0;
    end else if (rdy_in) begin
      state              <= state_n;
      flush_cnt          <= flush_cnt_n;
      rob_pop            <= rob_pop_n;
      rob_commit_reg     <= rob_commit_reg_n;
      rob_clear_up       <= rob_clear_up_n;
      redirect_valid     <= redirect_valid_n;
      commit_reg_id      <= commit_reg_id_n;
      commit_reg_data    <= commit_reg_data_n;
      commit_rob_entry   <= commit_rob_entry_n;
      store_commit_valid <= store_commit_valid_n;
      store_commit_entry <= store_commit_entry_n;
      redirect_pc        <= redirect_pc_n;
      halt_out           <= halt_n;
    end
  end

`ifdef COMMIT_CNT_EN
  logic [31:0] retired_q, mispred_q;

  // Count on the same edge that raises the corresponding pulse.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      retired_q <= 32'd0;
      mispred_q <= 32'd0;
    end else if (rdy_in) begin
      if (rob_pop_n)      retired_q <= retired_q + 32'd1;
      if (rob_clear_up_n) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign mispred_cnt = mispred_q;
`else
  assign retired_cnt = 32'd0;
  assign mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed testbench for commit_ctrl. Inputs change on the falling edge, and
// outputs are checked on the following falling edge.
module tb_commit_ctrl;
  localparam int RB = 5;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in;
  logic          head_valid, head_ready, head_mispredict;
  logic [1:0]    head_type;
  logic [4:0]    head_rd;
  logic [31:0]   head_value, head_target;
  logic [RB-1:0] head_entry;
  logic          store_commit_ack;
  logic          rob_pop, rob_commit_reg, store_commit_valid, rob_clear_up;
  logic          redirect_valid, halt_out;
  logic [4:0]    commit_reg_id;
  logic [31:0]   commit_reg_data, redirect_pc, retired_cnt, mispred_cnt;
  logic [RB-1:0] commit_rob_entry, store_commit_entry;
  logic [1:0]    fsm_state;

  int errors = 0;
  int checks = 0;

  commit_ctrl #(.ROB_BIT(RB), .FLUSH_WAIT(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .head_valid(head_valid), .head_ready(head_ready), .head_type(head_type),
    .head_rd(head_rd), .head_value(head_value), .head_entry(head_entry),
    .head_mispredict(head_mispredict), .head_target(head_target),
    .rob_pop(rob_pop), .rob_commit_reg(rob_commit_reg),
    .commit_reg_id(commit_reg_id), .commit_reg_data(commit_reg_data),
    .commit_rob_entry(commit_rob_entry),
    .store_commit_valid(store_commit_valid),
    .store_commit_entry(store_commit_entry),
    .store_commit_ack(store_commit_ack),
    .rob_clear_up(rob_clear_up), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt_out(halt_out),
    .retired_cnt(retired_cnt), .mispred_cnt(mispred_cnt),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic set_head(input logic v, input logic [1:0] t, input logic [4:0] rd,
                          input logic [31:0] val, input logic [RB-1:0] e,
                          input logic mis, input logic [31:0] tgt);
    head_valid = v; head_ready = v; head_type = t; head_rd = rd;
    head_value = val; head_entry = e; head_mispredict = mis; head_target = tgt;
  endtask

  task automatic clear_head();
    set_head(1'b0, 2'd0, 5'd0, 32'd0, '0, 1'b0, 32'd0);
  endtask

  // Expected counter values depend on whether the counters are built.
  task automatic check_cnt(input string tag, input logic [31:0] ret, input logic [31:0] mis);
`ifdef COMMIT_CNT_EN
    check({tag, "_retired"}, retired_cnt, ret);
    check({tag, "_mispred"}, mispred_cnt, mis);
`else
    check({tag, "_retired"}, retired_cnt, 32'd0);
    check({tag, "_mispred"}, mispred_cnt, 32'd0);
`endif
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; store_commit_ack = 1'b0;
    clear_head();
    step(); step();
    rst_in = 1'b0;
    step();
    check("rst_pop", rob_pop, 0);
    check("rst_commit", rob_commit_reg, 0);
    check("rst_store", store_commit_valid, 0);
    check("rst_clear", rob_clear_up, 0);
    check("rst_redirect", redirect_valid, 0);
    check("rst_halt", halt_out, 0);
    check("rst_state", fsm_state, 0);
    check_cnt("rst", 0, 0);

    // REG rd=5. The head is left stale for one more cycle to exercise the guard.
    set_head(1'b1, 2'd0, 5'd5, 32'hDEADBEEF, 5'd3, 1'b0, 32'd0);
    step();
    check("reg_pop", rob_pop, 1);
    check("reg_commit", rob_commit_reg, 1);
    check("reg_id", commit_reg_id, 5);
    check("reg_data", commit_reg_data, 32'hDEADBEEF);
    check("reg_entry", commit_rob_entry, 3);
    step();
    check("guard_pop", rob_pop, 0);
    check("guard_commit", rob_commit_reg, 0);
    clear_head();
    step();

    // REG rd=0 retires without a write.
    set_head(1'b1, 2'd0, 5'd0, 32'h55, 5'd4, 1'b0, 32'd0);
    step();
    check("rd0_pop", rob_pop, 1);
    check("rd0_commit", rob_commit_reg, 0);
    check("rd0_entry", commit_rob_entry, 4);
    clear_head();
    step();

    // STORE entry 7. The ack arrives in the fourth cycle valid is high.
    set_head(1'b1, 2'd1, 5'd0, 32'd0, 5'd7, 1'b0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("st_valid_%0d", i), store_commit_valid, 1);
      check($sformatf("st_nopop_%0d", i), rob_pop, 0);
    end
    check("st_entry", store_commit_entry, 7);
    check("st_state", fsm_state, 1);
    store_commit_ack = 1'b1;
    step();
    check("st_ack_valid", store_commit_valid, 0);
    check("st_ack_pop", rob_pop, 1);
    check("st_ack_state", fsm_state, 0);
    store_commit_ack = 1'b0;
    clear_head();
    step();
    check("st_after_pop", rob_pop, 0);

    // rdy_in low during WAIT_ST. The ack is ignored while frozen.
    set_head(1'b1, 2'd1, 5'd0, 32'd0, 5'd9, 1'b0, 32'd0);
    step();
    check("frz_st_valid0", store_commit_valid, 1);
    rdy_in = 1'b0; store_commit_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("frz_st_valid_%0d", i), store_commit_valid, 1);
      check($sformatf("frz_st_state_%0d", i), fsm_state, 1);
      check($sformatf("frz_st_pop_%0d", i), rob_pop, 0);
    end
    rdy_in = 1'b1;
    step();
    check("frz_st_done_valid", store_commit_valid, 0);
    check("frz_st_done_pop", rob_pop, 1);
    store_commit_ack = 1'b0;
    clear_head();
    step();

    // rdy_in low while rob_commit_reg is high. The pulses hold.
    set_head(1'b1, 2'd0, 5'd10, 32'h12345678, 5'd11, 1'b0, 32'd0);
    step();
    check("frz_reg_commit0", rob_commit_reg, 1);
    rdy_in = 1'b0;
    clear_head();
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("frz_reg_commit_%0d", i), rob_commit_reg, 1);
      check($sformatf("frz_reg_pop_%0d", i), rob_pop, 1);
      check($sformatf("frz_reg_id_%0d", i), commit_reg_id, 10);
    end
    rdy_in = 1'b1;
    step();
    check("frz_reg_release", rob_commit_reg, 0);
    check("frz_reg_release_pop", rob_pop, 0);

    // Mispredicted branch rd=1, target 0x100, followed by an already-ready REG.
    set_head(1'b1, 2'd2, 5'd1, 32'h44, 5'd12, 1'b1, 32'h100);
    step();
    check("mp_pop", rob_pop, 1);
    check("mp_commit", rob_commit_reg, 1);
    check("mp_id", commit_reg_id, 1);
    check("mp_clear", rob_clear_up, 1);
    check("mp_redirect", redirect_valid, 1);
    check("mp_pc", redirect_pc, 32'h100);
    check("mp_state", fsm_state, 2);
    set_head(1'b1, 2'd0, 5'd2, 32'h77, 5'd13, 1'b0, 32'd0);
    step();
    check("mp_clear_1cyc", rob_clear_up, 0);
    check("mp_redirect_1cyc", redirect_valid, 0);
    check("mp_flush1_pop", rob_pop, 0);
    step();
    check("mp_flush2_pop", rob_pop, 0);
    check("mp_back_run", fsm_state, 0);
    step();
    check("mp_resume_pop", rob_pop, 1);
    check("mp_resume_id", commit_reg_id, 2);
    clear_head();
    step();

    // A correctly predicted branch performs its link write.
    set_head(1'b1, 2'd2, 5'd3, 32'h2004, 5'd14, 1'b0, 32'h900);
    step();
    check("br_pop", rob_pop, 1);
    check("br_commit", rob_commit_reg, 1);
    check("br_data", commit_reg_data, 32'h2004);
    check("br_no_clear", rob_clear_up, 0);
    clear_head();
    step();
    check_cnt("cnt", 32'd8, 32'd1);

    // HALT is sticky, and later ready heads are ignored.
    set_head(1'b1, 2'd3, 5'd0, 32'd0, 5'd15, 1'b0, 32'd0);
    step();
    check("halt_out", halt_out, 1);
    check("halt_pop", rob_pop, 1);
    check("halt_state", fsm_state, 3);
    set_head(1'b1, 2'd0, 5'd4, 32'h99, 5'd16, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("halt_sticky_%0d", i), halt_out, 1);
      check($sformatf("halt_nopop_%0d", i), rob_pop, 0);
      check($sformatf("halt_nocommit_%0d", i), rob_commit_reg, 0);
    end
    check_cnt("halt_cnt", 32'd9, 32'd1);

    // Reset during WAIT_ST drops the pending store and clears halt.
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    set_head(1'b1, 2'd1, 5'd0, 32'd0, 5'd5, 1'b0, 32'd0);
    step();
    check("rst_mid_valid", store_commit_valid, 1);
    rst_in = 1'b1;
    step();
    check("rst_mid_valid_clr", store_commit_valid, 0);
    check("rst_mid_state", fsm_state, 0);
    check("rst_mid_halt", halt_out, 0);
    check_cnt("rst_mid", 0, 0);
    rst_in = 1'b0;
    clear_head();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
